tensor_core_result_reader: RTL

// - Drains a 4x4 tensor core result matrix out of the CPU, one element per handshake.
// - On start, takes a snapshot of the whole matrix in one cycle. It then streams the

---
 rtl/tensor_core_result_reader.sv | 101 ++++++++++
 1 files changed

// File: rtl/tensor_core_result_reader.sv
// Snapshots the ROWSxCOLS tensor core result matrix on start and streams it out
// one element per valid/ready handshake, tagged with row/col and a last flag.
module tensor_core_result_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                                     clock_in,
  input  logic                                     reset_in,
  input  logic                                     start_in,
  input  logic                                     col_major_in,
  input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] matrix_in,
  output logic                                     busy_out,
  output logic                                     out_valid,
  input  logic                                     out_ready_in,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic [$clog2(ROWS)-1:0]                  out_row,
  output logic [$clog2(COLS)-1:0]                  out_col,
  output logic                                     out_last,
  output logic                                     done_out
);
  // state  | meaning
  // IDLE   | waiting for start_in, snapshot ready to be overwritten
  // STREAM | presenting snapshot elements, advancing on each handshake
  // DONE   | one-cycle done pulse after the final transfer
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam int NUM   = ROWS * COLS;
  localparam int IDX_W = $clog2(NUM);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [IDX_W-1:0] ROWS_I   = IDX_W'(ROWS);
  localparam logic [IDX_W-1:0] COLS_I   = IDX_W'(COLS);

  state_t                                     state_q, state_d;
  logic [IDX_W-1:0]                           idx_q, idx_d;
  logic                                       col_major_q, col_major_d;
  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]  snap_q, snap_d;
  logic [ROW_W-1:0]                           rd_row;
  logic [COL_W-1:0]                           rd_col;

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      col_major_q <= 1'b0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_major_q <= col_major_d;
      snap_q      <= snap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_major_d = col_major_q;
    snap_d      = snap_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d     = STREAM;
          idx_d       = '0;
          col_major_d = col_major_in;
          snap_d      = matrix_in;
        end
      end
      STREAM: begin
        // out_valid is implied by STREAM, so ready alone marks a transfer
        if (out_ready_in) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (col_major_q) begin
      rd_row = ROW_W'(idx_q % ROWS_I);
      rd_col = COL_W'(idx_q / ROWS_I);
    end else begin
      rd_row = ROW_W'(idx_q / COLS_I);
      rd_col = COL_W'(idx_q % COLS_I);
    end
  end

  assign out_row   = rd_row;
  assign out_col   = rd_col;
  assign out_data  = snap_q[rd_row][rd_col];
  assign out_valid = (state_q == STREAM);
  assign out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign done_out  = (state_q == DONE);
  assign busy_out  = (state_q != IDLE);

endmodule
